// File: rtl/butterfly_pipe.sv
// butterfly_pipe: pipelined radix-2 fixed-point complex butterfly.
//   c = a + t, d = a - t, where t = w*b (mode 0) or a trivial rotation of b (modes 1-4).
//   Three register stages (S1 operand capture, S2 product, S3 sum/difference), one
//   butterfly per cycle, elastic valid/ready handshake on both sides. Capacity 3.
//
// Parameters:
//   N  total two's-complement word width (N >= 4)
//   D  fractional bits (0 <= D < N)
//
// Ports:
//   clk_i, reset_i             clock, synchronous active-high reset
//   recv_val_i / recv_rdy_o    input handshake
//   ar_i, ac_i                 operand a (real, imaginary)
//   br_i, bc_i                 operand b (real, imaginary)
//   wr_i, wc_i                 twiddle w (real, imaginary), ignored for modes 1-4
//   mode_i                     0: w*b, 1: +b, 2: -b, 3: +j*b, 4: -j*b, 5-7: as 0
//   send_val_o / send_rdy_i    output handshake
//   cr_o, cc_o, dr_o, dc_o     results c and d, held stable while stalled
//   sat_flag_o                 only with BUTTERFLY_PIPE_SAT_EN: a result or t saturated
//
// Build option: define BUTTERFLY_PIPE_SAT_EN to saturate instead of wrapping.

module butterfly_pipe #(
    parameter int unsigned N = 32,
    parameter int unsigned D = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         recv_val_i,
    output logic         recv_rdy_o,
    input  logic [N-1:0] ar_i,
    input  logic [N-1:0] ac_i,
    input  logic [N-1:0] br_i,
    input  logic [N-1:0] bc_i,
    input  logic [N-1:0] wr_i,
    input  logic [N-1:0] wc_i,
    input  logic [2:0]   mode_i,
    output logic         send_val_o,
    input  logic         send_rdy_i,
    output logic [N-1:0] cr_o,
    output logic [N-1:0] cc_o,
    output logic [N-1:0] dr_o,
    output logic [N-1:0] dc_o
`ifdef BUTTERFLY_PIPE_SAT_EN
    ,
    output logic         sat_flag_o
`endif
);

    typedef enum logic [2:0] {
        ModeMul    = 3'd0,
        ModePosOne = 3'd1,
        ModeNegOne = 3'd2,
        ModePosJ   = 3'd3,
        ModeNegJ   = 3'd4
    } mode_e;

    function automatic logic [2*N-1:0] sext2(input logic [N-1:0] x);
        return {{N{x[N-1]}}, x};
    endfunction

`ifdef BUTTERFLY_PIPE_SAT_EN
    // Shifted product fits in N bits iff its top N+2 bits are all equal.
    function automatic logic prod_ovf(input logic [2*N:0] v);
        return ~((&v[2*N:N-1]) | ~(|v[2*N:N-1]));
    endfunction

    function automatic logic [N-1:0] prod_sat(input logic [2*N:0] v);
        if (prod_ovf(v)) begin
            return {v[2*N], {(N-1){~v[2*N]}}};
        end
        return v[N-1:0];
    endfunction

    function automatic logic [N:0] add_ext(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic sub);
        if (sub) begin
            return {a[N-1], a} - {b[N-1], b};
        end
        return {a[N-1], a} + {b[N-1], b};
    endfunction

    function automatic logic sum_ovf(input logic [N:0] s);
        return s[N] ^ s[N-1];
    endfunction

    function automatic logic [N-1:0] sum_sat(input logic [N:0] s);
        if (sum_ovf(s)) begin
            return {s[N], {(N-1){~s[N]}}};
        end
        return s[N-1:0];
    endfunction
`endif

    // Handshake / stage control
    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;
    logic adv1, adv2, adv3;
    logic ld1, ld2, ld3;

    // S1: captured operands
    logic [N-1:0] ar_s1_q, ac_s1_q, br_s1_q, bc_s1_q, wr_s1_q, wc_s1_q;
    mode_e        mode_s1_q;

    // S2: a delayed, t computed
    logic [N-1:0] ar_s2_q, ac_s2_q, tr_s2_q, tc_s2_q;
    logic [N-1:0] tr_d, tc_d;

    // S3: outputs
    logic [N-1:0] cr_q, cc_q, dr_q, dc_q;
    logic [N-1:0] cr_d, cc_d, dr_d, dc_d;

    logic [2*N-1:0]    p_rr, p_ii, p_ri, p_ir;
    logic signed [2*N:0] pr_sum, pc_sum;

`ifdef BUTTERFLY_PIPE_SAT_EN
    logic signed [2*N:0] pr_shf, pc_shf;
    logic tsat_s2_q, tsat_d;
    logic sat_q, sat_d;
    logic [N:0] cr_ext, cc_ext, dr_ext, dc_ext;
`endif

    always_comb begin
        adv3 = ~v3_q | send_rdy_i;
        adv2 = ~v2_q | adv3;
        adv1 = ~v1_q | adv2;

        // An advancing stage takes its predecessor's valid, which clears it when empty.
        v1_d = adv1 ? recv_val_i : v1_q;
        v2_d = adv2 ? v1_q : v2_q;
        v3_d = adv3 ? v2_q : v3_q;

        // Data only moves with a real transaction so the outputs stay put otherwise.
        ld1 = adv1 & recv_val_i;
        ld2 = adv2 & v1_q;
        ld3 = adv3 & v2_q;
    end

    assign recv_rdy_o = adv1;
    assign send_val_o = v3_q;

    // S2: complex product (or rotation) of b by w
    always_comb begin
        p_rr = sext2(br_s1_q) * sext2(wr_s1_q);
        p_ii = sext2(bc_s1_q) * sext2(wc_s1_q);
        p_ri = sext2(br_s1_q) * sext2(wc_s1_q);
        p_ir = sext2(bc_s1_q) * sext2(wr_s1_q);
        pr_sum = {p_rr[2*N-1], p_rr} - {p_ii[2*N-1], p_ii};
        pc_sum = {p_ri[2*N-1], p_ri} + {p_ir[2*N-1], p_ir};
`ifdef BUTTERFLY_PIPE_SAT_EN
        pr_shf = pr_sum >>> D;
        pc_shf = pc_sum >>> D;
        tsat_d = 1'b0;
`endif
        tr_d = '0;
        tc_d = '0;
        case (mode_s1_q)
            ModePosOne: begin
                tr_d = br_s1_q;
                tc_d = bc_s1_q;
            end
            ModeNegOne: begin
                tr_d = '0 - br_s1_q;
                tc_d = '0 - bc_s1_q;
            end
            ModePosJ: begin
                tr_d = '0 - bc_s1_q;
                tc_d = br_s1_q;
            end
            ModeNegJ: begin
                tr_d = bc_s1_q;
                tc_d = '0 - br_s1_q;
            end
            default: begin
`ifdef BUTTERFLY_PIPE_SAT_EN
                tr_d   = prod_sat(pr_shf);
                tc_d   = prod_sat(pc_shf);
                tsat_d = prod_ovf(pr_shf) | prod_ovf(pc_shf);
`else
                // Floor shift of the full-width sum, then keep the low N bits.
                tr_d = N'(pr_sum >>> D);
                tc_d = N'(pc_sum >>> D);
`endif
            end
        endcase
    end

    // S3: sum and difference
    always_comb begin
`ifdef BUTTERFLY_PIPE_SAT_EN
        cr_ext = add_ext(ar_s2_q, tr_s2_q, 1'b0);
        cc_ext = add_ext(ac_s2_q, tc_s2_q, 1'b0);
        dr_ext = add_ext(ar_s2_q, tr_s2_q, 1'b1);
        dc_ext = add_ext(ac_s2_q, tc_s2_q, 1'b1);
        cr_d   = sum_sat(cr_ext);
        cc_d   = sum_sat(cc_ext);
        dr_d   = sum_sat(dr_ext);
        dc_d   = sum_sat(dc_ext);
        sat_d  = tsat_s2_q | sum_ovf(cr_ext) | sum_ovf(cc_ext) | sum_ovf(dr_ext)
               | sum_ovf(dc_ext);
`else
        cr_d = ar_s2_q + tr_s2_q;
        cc_d = ac_s2_q + tc_s2_q;
        dr_d = ar_s2_q - tr_s2_q;
        dc_d = ac_s2_q - tc_s2_q;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            ar_s1_q   <= '0;
            ac_s1_q   <= '0;
            br_s1_q   <= '0;
            bc_s1_q   <= '0;
            wr_s1_q   <= '0;
            wc_s1_q   <= '0;
            mode_s1_q <= ModeMul;
            ar_s2_q   <= '0;
            ac_s2_q   <= '0;
            tr_s2_q   <= '0;
            tc_s2_q   <= '0;
            cr_q      <= '0;
            cc_q      <= '0;
            dr_q      <= '0;
            dc_q      <= '0;
`ifdef BUTTERFLY_PIPE_SAT_EN
            tsat_s2_q <= 1'b0;
            sat_q     <= 1'b0;
`endif
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            if (ld1) begin
                ar_s1_q   <= ar_i;
                ac_s1_q   <= ac_i;
                br_s1_q   <= br_i;
                bc_s1_q   <= bc_i;
                wr_s1_q   <= wr_i;
                wc_s1_q   <= wc_i;
                mode_s1_q <= mode_e'(mode_i);
            end
            if (ld2) begin
                ar_s2_q <= ar_s1_q;
                ac_s2_q <= ac_s1_q;
                tr_s2_q <= tr_d;
                tc_s2_q <= tc_d;
`ifdef BUTTERFLY_PIPE_SAT_EN
                tsat_s2_q <= tsat_d;
`endif
            end
            if (ld3) begin
                cr_q <= cr_d;
                cc_q <= cc_d;
                dr_q <= dr_d;
                dc_q <= dc_d;
`ifdef BUTTERFLY_PIPE_SAT_EN
                sat_q <= sat_d;
`endif
            end
        end
    end

    assign cr_o = cr_q;
    assign cc_o = cc_q;
    assign dr_o = dr_q;
    assign dc_o = dc_q;
`ifdef BUTTERFLY_PIPE_SAT_EN
    assign sat_flag_o = sat_q;
`endif

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe (N=32, D=16). Expected results come from an
// integer-arithmetic model of the butterfly, queued per accepted transaction.
module tb_butterfly_pipe;

    localparam int unsigned N = 32;
    localparam int unsigned D = 16;
`ifdef BUTTERFLY_PIPE_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    logic         clk, reset;
    logic         recv_val, recv_rdy, send_val, send_rdy;
    logic [N-1:0] ar, ac, br, bc, wr, wc;
    logic [2:0]   mode;
    logic [N-1:0] cr, cc, dr, dc;
    logic         sat_flag;

    butterfly_pipe #(.N(N), .D(D)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .recv_val_i (recv_val),
        .recv_rdy_o (recv_rdy),
        .ar_i       (ar),
        .ac_i       (ac),
        .br_i       (br),
        .bc_i       (bc),
        .wr_i       (wr),
        .wc_i       (wc),
        .mode_i     (mode),
        .send_val_o (send_val),
        .send_rdy_i (send_rdy),
        .cr_o       (cr),
        .cc_o       (cc),
        .dr_o       (dr),
        .dc_o       (dc)
`ifdef BUTTERFLY_PIPE_SAT_EN
        ,
        .sat_flag_o (sat_flag)
`endif
    );
`ifndef BUTTERFLY_PIPE_SAT_EN
    assign sat_flag = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] ar, ac, br, bc, wr, wc;
        logic [2:0]   mode;
    } txn_t;

    typedef struct {
        logic [N-1:0] cr, cc, dr, dc;
        logic         sat;
    } res_t;

    res_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reduce an exact integer to N bits: clamp when saturation applies, else wrap.
    function automatic logic [N-1:0] fit(input logic signed [127:0] x, input bit sat_ok,
                                         output bit s);
        logic signed [127:0] maxv, minv;
        maxv = (128'sd1 <<< (N - 1)) - 128'sd1;
        minv = -(128'sd1 <<< (N - 1));
        s = 1'b0;
        if (SatEn && sat_ok && x > maxv) begin
            s = 1'b1;
            return maxv[N-1:0];
        end
        if (SatEn && sat_ok && x < minv) begin
            s = 1'b1;
            return minv[N-1:0];
        end
        return x[N-1:0];
    endfunction

    function automatic res_t model(input txn_t t);
        logic signed [127:0] a_r, a_c, b_r, b_c, w_r, w_c, p, t_r, t_c;
        bit   s0, s1, s2, s3, s4, s5;
        res_t r;
        a_r = $signed(t.ar);
        a_c = $signed(t.ac);
        b_r = $signed(t.br);
        b_c = $signed(t.bc);
        w_r = $signed(t.wr);
        w_c = $signed(t.wc);
        if (t.mode >= 3'd1 && t.mode <= 3'd4) begin
            case (t.mode)
                3'd1:    begin t_r = b_r;  t_c = b_c;  end
                3'd2:    begin t_r = -b_r; t_c = -b_c; end
                3'd3:    begin t_r = -b_c; t_c = b_r;  end
                default: begin t_r = b_c;  t_c = -b_r; end
            endcase
            t_r = $signed(fit(t_r, 1'b0, s0));
            t_c = $signed(fit(t_c, 1'b0, s1));
        end else begin
            p   = (b_r * w_r - b_c * w_c) >>> D;
            t_r = $signed(fit(p, 1'b1, s0));
            p   = (b_r * w_c + b_c * w_r) >>> D;
            t_c = $signed(fit(p, 1'b1, s1));
        end
        r.cr  = fit(a_r + t_r, 1'b1, s2);
        r.cc  = fit(a_c + t_c, 1'b1, s3);
        r.dr  = fit(a_r - t_r, 1'b1, s4);
        r.dc  = fit(a_c - t_c, 1'b1, s5);
        r.sat = s0 | s1 | s2 | s3 | s4 | s5;
        return r;
    endfunction

    function automatic logic [N-1:0] rword();
        logic [N-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h7FFF_FFFF;
            1:       v = 32'h8000_0000;
            2:       v = 32'($urandom_range(0, 32'h0003_FFFF));
            3:       v = 32'h0 - 32'($urandom_range(0, 32'h0003_FFFF));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    function automatic txn_t rtxn(input int unsigned max_mode);
        txn_t t;
        t.ar   = rword();
        t.ac   = rword();
        t.br   = rword();
        t.bc   = rword();
        t.wr   = rword();
        t.wc   = rword();
        t.mode = 3'($urandom_range(0, max_mode));
        return t;
    endfunction

    function automatic txn_t mk(input logic [N-1:0] a_r, input logic [N-1:0] b_r,
                                input logic [N-1:0] w_r, input logic [2:0] m);
        txn_t t;
        t = rtxn(7);
        t.ar = a_r; t.ac = '0; t.br = b_r; t.bc = '0; t.mode = m;
        if (m == 3'd0) begin
            t.wr = w_r;
            t.wc = '0;
        end
        return t;
    endfunction

    // One cycle: drive, sample just before the edge, record accept in the model queue.
    task automatic slot(input txn_t t, input bit val, input bit srdy,
                        output bit acc, output bit sv, output res_t obs);
        recv_val = val;
        send_rdy = srdy;
        ar = t.ar; ac = t.ac; br = t.br; bc = t.bc; wr = t.wr; wc = t.wc; mode = t.mode;
        #1;
        acc = val && (recv_rdy === 1'b1);
        sv  = (send_val === 1'b1);
        obs.cr = cr; obs.cc = cc; obs.dr = dr; obs.dc = dc; obs.sat = sat_flag;
        if (acc) exp_q.push_back(model(t));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        txn_t t;
        bit   acc, sv;
        res_t obs;
        t = rtxn(7);
        reset = 1'b1;
        slot(t, 1'b0, 1'b0, acc, sv, obs);
        slot(t, 1'b0, 1'b0, acc, sv, obs);
        reset = 1'b0;
        #1;
        vectors++;
        if (send_val !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_send_val: got %b want 0", send_val);
        end
        vectors++;
        if ({cr, cc, dr, dc, sat_flag} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h %h %h %h sat %b want all 0",
                     cr, cc, dr, dc, sat_flag);
        end
        vectors++;
        if (recv_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_recv_rdy: got %b want 1", recv_rdy);
        end
    endtask

    // Single transaction: latency of three edges and fixed expected values.
    task automatic directed(input string name, input txn_t t, input res_t want);
        bit   acc, sv;
        res_t obs, e;
        slot(t, 1'b1, 1'b1, acc, sv, obs);
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL %s_accept: got 0 want 1", name);
        end
        for (int k = 1; k <= 4; k++) begin
            slot(t, 1'b0, 1'b1, acc, sv, obs);
            vectors++;
            if (sv !== (k == 3)) begin
                miscompares++;
                $display("FAIL %s_latency slot %0d: send_val %b want %b", name, k, sv, k == 3);
            end
            if (sv) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : want;
                vectors++;
                if ({obs.cr, obs.cc, obs.dr, obs.dc, obs.sat} !==
                    {want.cr, want.cc, want.dr, want.dc, want.sat}) begin
                    miscompares++;
                    $display("FAIL %s_value: got %h %h %h %h sat %b want %h %h %h %h sat %b",
                             name, obs.cr, obs.cc, obs.dr, obs.dc, obs.sat,
                             want.cr, want.cc, want.dr, want.dc, want.sat);
                end
                vectors++;
                if ({e.cr, e.cc, e.dr, e.dc, e.sat} !== {obs.cr, obs.cc, obs.dr, obs.dc, obs.sat})
                begin
                    miscompares++;
                    $display("FAIL %s_model: got %h %h %h %h want %h %h %h %h",
                             name, obs.cr, obs.cc, obs.dr, obs.dc, e.cr, e.cc, e.dr, e.dc);
                end
            end
        end
    endtask

    task automatic test_general();
        res_t w;
        w.cr = 32'h0002_0000; w.cc = '0; w.dr = '0; w.dc = '0; w.sat = 1'b0;
        directed("general", mk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 3'd0), w);
    endtask

    task automatic test_plus_j();
        res_t w;
        w.cr = 32'h0001_0000; w.cc = 32'h0001_0000;
        w.dr = 32'h0001_0000; w.dc = 32'hFFFF_0000; w.sat = 1'b0;
        directed("plus_j", mk(32'h0001_0000, 32'h0001_0000, '0, 3'd3), w);
    endtask

    task automatic test_wrap();
        res_t w;
        txn_t t;
        t = mk(32'h7FFF_FFFF, 32'h0000_0001, '0, 3'd1);
        w.cc = '0; w.dr = 32'h7FFF_FFFE; w.dc = '0;
        w.cr  = SatEn ? 32'h7FFF_FFFF : 32'h8000_0000;
        w.sat = SatEn;
        directed("wrap_sat", t, w);
    endtask

    task automatic test_backpressure();
        txn_t t;
        bit   acc, sv;
        res_t obs, e;
        logic [N-1:0] tag = 1;
        for (int i = 0; i < 6; i++) begin
            t = rtxn(4);
            t.ar = tag;
            slot(t, 1'b1, 1'b0, acc, sv, obs);
            vectors++;
            if (acc !== (i < 3)) begin
                miscompares++;
                $display("FAIL bp_fill_accept slot %0d: got %b want %b", i, acc, i < 3);
            end
            if (acc) tag++;
            if (i >= 3) begin
                vectors++;
                if (!sv || exp_q.size() == 0 ||
                    {obs.cr, obs.cc, obs.dr, obs.dc} !==
                    {exp_q[0].cr, exp_q[0].cc, exp_q[0].dr, exp_q[0].dc}) begin
                    miscompares++;
                    $display("FAIL bp_hold slot %0d: send_val %b cr %h", i, sv, obs.cr);
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            t = rtxn(4);
            t.ar = tag;
            slot(t, tag <= 4, 1'b1, acc, sv, obs);
            if (acc) tag++;
            if (i == 0) begin
                vectors++;
                if (!acc) begin
                    miscompares++;
                    $display("FAIL bp_accept4: got 0 want 1");
                end
            end
            vectors++;
            if (sv !== (i < 4)) begin
                miscompares++;
                $display("FAIL bp_drain_valid slot %0d: got %b want %b", i, sv, i < 4);
            end
            if (sv) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '{default: 'x};
                vectors++;
                if ({obs.cr, obs.cc, obs.dr, obs.dc, obs.sat} !== {e.cr, e.cc, e.dr, e.dc, e.sat})
                begin
                    miscompares++;
                    $display("FAIL bp_order slot %0d: got cr %h want cr %h", i, obs.cr, e.cr);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        txn_t t;
        bit   acc, sv;
        res_t obs, e;
        int   seen = 0;
        for (int i = 0; i < 19; i++) begin
            t = rtxn(4);
            slot(t, i < 16, 1'b1, acc, sv, obs);
            if (i < 16) begin
                vectors++;
                if (!acc) begin
                    miscompares++;
                    $display("FAIL stream_rdy slot %0d: got 0 want 1", i);
                end
            end
            vectors++;
            if (sv !== (i >= 3)) begin
                miscompares++;
                $display("FAIL stream_valid slot %0d: got %b want %b", i, sv, i >= 3);
            end
            if (sv && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                seen++;
                vectors++;
                if ({obs.cr, obs.cc, obs.dr, obs.dc, obs.sat} !== {e.cr, e.cc, e.dr, e.dc, e.sat})
                begin
                    miscompares++;
                    $display("FAIL stream_data #%0d: got %h %h %h %h want %h %h %h %h", seen,
                             obs.cr, obs.cc, obs.dr, obs.dc, e.cr, e.cc, e.dr, e.dc);
                end
            end
        end
        vectors++;
        if (seen != 16) begin
            miscompares++;
            $display("FAIL stream_count: got %0d want 16", seen);
        end
    endtask

    task automatic test_reset_mid();
        txn_t t;
        bit   acc, sv;
        res_t obs, w;
        for (int i = 0; i < 2; i++) begin
            t = rtxn(4);
            slot(t, 1'b1, 1'b1, acc, sv, obs);
        end
        reset = 1'b1;
        slot(t, 1'b0, 1'b1, acc, sv, obs);
        reset = 1'b0;
        exp_q.delete();
        vectors++;
        if (send_val !== 1'b0 || {cr, cc, dr, dc, sat_flag} !== '0) begin
            miscompares++;
            $display("FAIL midreset_clear: send_val %b outputs %h %h %h %h want 0",
                     send_val, cr, cc, dr, dc);
        end
        for (int i = 0; i < 4; i++) begin
            slot(t, 1'b0, 1'b1, acc, sv, obs);
            vectors++;
            if (sv) begin
                miscompares++;
                $display("FAIL midreset_stale slot %0d: got send_val 1 want 0", i);
            end
        end
        w.cr = 32'h0002_0000; w.cc = '0; w.dr = '0; w.dc = '0; w.sat = 1'b0;
        directed("after_reset", mk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 3'd0), w);
    endtask

    task automatic test_random_stall();
        txn_t t;
        bit   acc, sv, srdy, hold;
        res_t obs, prev, e;
        hold = 1'b0;
        for (int i = 0; i < 420; i++) begin
            t    = rtxn(7);
            srdy = (i >= 400) || ($urandom_range(0, 3) != 0);
            slot(t, (i < 400) && ($urandom_range(0, 3) != 0), srdy, acc, sv, obs);
            if (hold) begin
                vectors++;
                if (!sv || {obs.cr, obs.cc, obs.dr, obs.dc, obs.sat} !==
                           {prev.cr, prev.cc, prev.dr, prev.dc, prev.sat}) begin
                    miscompares++;
                    $display("FAIL rand_hold slot %0d: got cr %h want cr %h", i, obs.cr, prev.cr);
                end
            end
            if (sv && srdy) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_extra slot %0d: got output want none", i);
                end else begin
                    e = exp_q.pop_front();
                    if ({obs.cr, obs.cc, obs.dr, obs.dc, obs.sat} !==
                        {e.cr, e.cc, e.dr, e.dc, e.sat}) begin
                        miscompares++;
                        $display("FAIL rand_data slot %0d: got %h %h %h %h %b want %h %h %h %h %b",
                                 i, obs.cr, obs.cc, obs.dr, obs.dc, obs.sat,
                                 e.cr, e.cc, e.dr, e.dc, e.sat);
                    end
                end
            end
            hold = sv && !srdy;
            prev = obs;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rand_drain: got %0d pending want 0", exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b0;
        ar = '0; ac = '0; br = '0; bc = '0; wr = '0; wc = '0; mode = '0;
        test_reset();
        test_general();
        test_plus_j();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
